l1_rd_mport: RTL and testbench
==============================

# l1_rd_mport

Multi-port L1 read-address generator for the multi-stream buffer. Accepts up to `nports` read requests per cycle, each naming a stream id. Owns per-stream read pointers and read credits, resolves same-stream collisions within a cycle by port priority, and drives one registered BRAM address per port. It replaces a bank of per-port combinational address calculators and sits between the stream read arbiter and the L1 BRAM read ports.

## Interface
Parameters:
- `nstrms`, 64, number of streams; `nstrms_width` = $clog2(nstrms)
- `nports`, 8, number of read ports
- `ptr_width`, 4, L1 line pointer width; pointers wrap modulo 2^ptr_width
- `cl_size`, 8, credits added per landed cacheline; must satisfy nports <= cl_size <= 2^ptr_width
- `cnt_width`, ptr_width+1, per-stream credit counter width

Ports:
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `i_rd_v`  in  nports  per-port read request valid
- `i_rd_r`  out  nports  per-port read accepted
- `i_rd_sid`  in  nports*nstrms_width  per-port stream id; port p at bits [p*nstrms_width +: nstrms_width]
- `i_fill_v`  in  1  one cacheline landed in L1 for `i_fill_sid`
- `i_fill_sid`  in  nstrms_width  stream receiving the cacheline
- `i_rst_v`  in  1  reset one stream's pointer and credits
- `i_rst_sid`  in  nstrms_width  stream to reset
- `o_addr_v`  out  nports  per-port registered address valid
- `o_addr_r`  in  nports  per-port BRAM ready
- `o_addr_ptr`  out  nports*ptr_width  per-port line pointer
- `o_addr_sid`  out  nports*nstrms_width  per-port stream id
- `o_err`  out  1  sticky credit overflow/underflow flag

## Operation
- State per stream s: `ptr[s]` (ptr_width bits) and `avail[s]` (cnt_width bits). State per port: one output register (valid, ptr, sid).
- Slot free for port p: `~o_addr_v[p] | o_addr_r[p]`.
- Grant rule, evaluated in port order 0..nports-1. Let k_p be the number of lower ports granted with the same sid. Then:
  - `grant[p] = i_rd_v[p] & slot_free[p] & ~(i_rst_v & i_rst_sid==sid_p) & (avail[sid_p] > k_p)`
  - `i_rd_r = grant`.
- Ready may depend combinationally on lower-port valids and sids, and on `o_addr_r`.
- On grant, port p's register loads ptr = (`ptr[sid_p]` + k_p) mod 2^ptr_width and sid = sid_p; valid is set.
- If port p is not granted and `o_addr_r[p]` is high, its valid clears. Otherwise the register holds.
- Per-stream update, where n = total grants to stream s this cycle:
  - `ptr[s] += n` (mod 2^ptr_width)
  - `avail[s] = avail[s] - n + (i_fill_v & i_fill_sid==s ? cl_size : 0)`
- A fill is not usable for grants in the cycle it arrives.
- `i_rst_v` on stream s forces `ptr[s]=0` and `avail[s]=0`. It overrides a same-cycle fill, and same-cycle reads to s are refused.
- Overflow: the computed avail exceeds 2^cnt_width-1. The counter saturates at maximum.

## Timing
- Reset values: all `ptr`, `avail` = 0; `o_addr_v` = 0, `o_addr_ptr` = 0, `o_addr_sid` = 0; `o_err` = 0.
- Latency: a grant in cycle t presents the address in cycle t+1.
- Throughput: one read per port per cycle when `o_addr_r` is held high.
- While `o_addr_v[p]` is high and `o_addr_r[p]` is low, `o_addr_ptr` and `o_addr_sid` for port p hold stable, and `i_rd_r[p]`=0.
- Pointer updates are visible to grants in cycle t+1, so back-to-back same-stream reads are contiguous.
- Asserting `reset` mid-operation drops all in-flight outputs immediately (asynchronous).

## Configuration
- `L1_RD_MPORT_ERR_EN` defined:
  - `o_err` sets on credit-counter overflow.
  - `o_err` also sets if internal accounting would take avail negative. This is unreachable by design and is checked as an assertion.
  - `o_err` clears only on `reset`.
- Macro undefined: `o_err` is tied 0 and no detection logic is built. Saturation behaviour is unchanged.

## Test plan
- Fill sid 3 once (cl_size=8), then drive 9 single-port reads on port 0 with `o_addr_r`=1. Required: ptrs 0..7 out; 9th read held with `i_rd_r[0]`=0.
- Set sid 5 to ptr=2, avail=8. Ports 0,1,2 request sid 5 in one cycle. Required: next cycle ptrs 2,3,4; then `ptr[5]`=5, `avail[5]`=5.
- Set sid 1 to avail=2. Ports 0..3 request sid 1. Required: `i_rd_r`=4'b0011; ports 2,3 are granted after the next fill.
- Wrap with ptr_width=4: sid 7 at ptr=14, avail=8, four same-cycle reads. Required: ptrs 14,15,0,1; `ptr[7]`=2.
- Backpressure: port 0 valid with `o_addr_r[0]`=0 for 3 cycles. Required: output stable, `i_rd_r[0]`=0, avail unchanged. Release: transfer completes, then a new grant.
- `i_rst_v`, `i_fill_v` and a port-0 read all on sid 2 in the same cycle. Required: read refused; next cycle ptr=0, avail=0.
  - With `L1_RD_MPORT_ERR_EN`, additionally: with cl_size=8, cnt_width=5, fill sid 0 four times without reads. Required: avail saturates at 31 and `o_err`=1.

Source files
------------

// File: rtl/l1_rd_mport.sv
// Purpose: multi-port L1 read-address generator; owns per-stream read pointers and credits.
// Latency: a read granted in cycle t presents its registered BRAM address in cycle t+1.
// Backpressure: a port holds its address while o_addr_r is low and refuses new reads (i_rd_r=0).
// Ports: clk, reset (async, active-high); i_rd_v/i_rd_r/i_rd_sid per-port read requests;
//        i_fill_v/i_fill_sid landed cacheline (+cl_size credits); i_rst_v/i_rst_sid per-stream clear;
//        o_addr_v/o_addr_r/o_addr_ptr/o_addr_sid per-port registered address; o_err sticky error.
// Option: define L1_RD_MPORT_ERR_EN to build the credit overflow/underflow flag on o_err.
module l1_rd_mport #(
  parameter int nstrms       = 64,
  parameter int nports       = 8,
  parameter int ptr_width    = 4,
  parameter int cl_size      = 8,
  parameter int cnt_width    = ptr_width + 1,
  parameter int nstrms_width = $clog2(nstrms)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [nports-1:0]              i_rd_v,
  output logic [nports-1:0]              i_rd_r,
  input  logic [nports*nstrms_width-1:0] i_rd_sid,
  input  logic                           i_fill_v,
  input  logic [nstrms_width-1:0]        i_fill_sid,
  input  logic                           i_rst_v,
  input  logic [nstrms_width-1:0]        i_rst_sid,
  output logic [nports-1:0]              o_addr_v,
  input  logic [nports-1:0]              o_addr_r,
  output logic [nports*ptr_width-1:0]    o_addr_ptr,
  output logic [nports*nstrms_width-1:0] o_addr_sid,
  output logic                           o_err
);

  // One spare bit so avail - n + cl_size can be checked against the counter maximum.
  localparam logic [cnt_width:0] avail_max = {1'b0, {cnt_width{1'b1}}};
  localparam logic [cnt_width:0] fill_add  = (cnt_width+1)'(cl_size);

  logic [ptr_width-1:0]    ptr_q    [nstrms];
  logic [cnt_width-1:0]    avail_q  [nstrms];
  logic [ptr_width-1:0]    ptr_d    [nstrms];
  logic [cnt_width-1:0]    avail_d  [nstrms];
  logic [cnt_width:0]      n_s      [nstrms];
  logic [cnt_width:0]      sum_s    [nstrms];

  logic [nstrms_width-1:0] port_sid [nports];
  logic [cnt_width-1:0]    port_k   [nports];
  logic [nports-1:0]       grant;

`ifdef L1_RD_MPORT_ERR_EN
  logic ovf_any;
  logic unf_any;
`endif

  // Port-priority grant: port_k counts lower-numbered ports already granted on the same
  // stream, so the p-th same-stream grant needs more than port_k credits and takes ptr+port_k.
  always_comb begin
    grant = '0;
    for (int p = 0; p < nports; p++) begin
      port_sid[p] = i_rd_sid[p*nstrms_width +: nstrms_width];
      port_k[p]   = '0;
      for (int q = 0; q < p; q++) begin
        if (grant[q] && port_sid[q] == port_sid[p])
          port_k[p] = port_k[p] + cnt_width'(1);
      end
      grant[p] = i_rd_v[p] & (~o_addr_v[p] | o_addr_r[p])
               & ~(i_rst_v && i_rst_sid == port_sid[p])
               & (avail_q[port_sid[p]] > port_k[p]);
    end
  end

  assign i_rd_r = grant;

  // Per-stream pointer/credit update. A fill lands in avail_q and is only usable next cycle.
  always_comb begin
`ifdef L1_RD_MPORT_ERR_EN
    ovf_any = 1'b0;
    unf_any = 1'b0;
`endif
    for (int s = 0; s < nstrms; s++) begin
      n_s[s] = '0;
      for (int p = 0; p < nports; p++) begin
        if (grant[p] && port_sid[p] == nstrms_width'(s))
          n_s[s] = n_s[s] + (cnt_width+1)'(1);
      end
      sum_s[s] = {1'b0, avail_q[s]} - n_s[s];
      if (i_fill_v && i_fill_sid == nstrms_width'(s))
        sum_s[s] = sum_s[s] + fill_add;
      ptr_d[s] = ptr_q[s] + ptr_width'(n_s[s]);
      if (i_rst_v && i_rst_sid == nstrms_width'(s)) begin
        ptr_d[s]   = '0;
        avail_d[s] = '0;
      end else if ({1'b0, avail_q[s]} < n_s[s]) begin
        // Grants never exceed credits; this branch only guards against broken accounting.
        avail_d[s] = '0;
`ifdef L1_RD_MPORT_ERR_EN
        unf_any = 1'b1;
`endif
      end else if (sum_s[s] > avail_max) begin
        avail_d[s] = '1;
`ifdef L1_RD_MPORT_ERR_EN
        ovf_any = 1'b1;
`endif
      end else begin
        avail_d[s] = sum_s[s][cnt_width-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < nstrms; s++) begin
        ptr_q[s]   <= '0;
        avail_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < nstrms; s++) begin
        ptr_q[s]   <= ptr_d[s];
        avail_q[s] <= avail_d[s];
      end
    end
  end

  // Output registers: load on grant, drop valid when the BRAM takes it, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_addr_v   <= '0;
      o_addr_ptr <= '0;
      o_addr_sid <= '0;
    end else begin
      for (int p = 0; p < nports; p++) begin
        if (grant[p]) begin
          o_addr_v[p]                                  <= 1'b1;
          o_addr_ptr[p*ptr_width +: ptr_width]         <= ptr_q[port_sid[p]] + ptr_width'(port_k[p]);
          o_addr_sid[p*nstrms_width +: nstrms_width]   <= port_sid[p];
        end else if (o_addr_r[p]) begin
          o_addr_v[p] <= 1'b0;
        end
      end
    end
  end

`ifdef L1_RD_MPORT_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (ovf_any || unf_any)
      err_q <= 1'b1;
  end

  assign o_err = err_q;

  credit_never_negative: assert property (@(posedge clk) disable iff (reset) !unf_any);
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_l1_rd_mport.sv
module tb_l1_rd_mport;

  localparam int NS   = 64;
  localparam int NP   = 8;
  localparam int PW   = 4;
  localparam int CL   = 8;
  localparam int CW   = PW + 1;
  localparam int SW   = 6;
  localparam int PMOD = 1 << PW;
  localparam int AMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     i_rd_v = '0;
  logic [NP-1:0]     i_rd_r;
  logic [NP*SW-1:0]  i_rd_sid = '0;
  logic              i_fill_v = 1'b0;
  logic [SW-1:0]     i_fill_sid = '0;
  logic              i_rst_v = 1'b0;
  logic [SW-1:0]     i_rst_sid = '0;
  logic [NP-1:0]     o_addr_v;
  logic [NP-1:0]     o_addr_r = '1;
  logic [NP*PW-1:0]  o_addr_ptr;
  logic [NP*SW-1:0]  o_addr_sid;
  logic              o_err;

  l1_rd_mport #(.nstrms(NS), .nports(NP), .ptr_width(PW), .cl_size(CL)) dut (
    .clk(clk), .reset(reset),
    .i_rd_v(i_rd_v), .i_rd_r(i_rd_r), .i_rd_sid(i_rd_sid),
    .i_fill_v(i_fill_v), .i_fill_sid(i_fill_sid),
    .i_rst_v(i_rst_v), .i_rst_sid(i_rst_sid),
    .o_addr_v(o_addr_v), .o_addr_r(o_addr_r),
    .o_addr_ptr(o_addr_ptr), .o_addr_sid(o_addr_sid),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [NP-1:0] got_rd_r;

  // Reference model: credits and pointers as plain integers.
  int            m_ptr  [NS];
  int            m_av   [NS];
  int            taken  [NS];
  logic [NP-1:0] m_v;
  logic [NP-1:0] m_g;
  int            m_optr [NP];
  int            m_osid [NP];
  int            nptr   [NP];
  int            nsid   [NP];
  bit            m_err;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin m_ptr[s] = 0; m_av[s] = 0; end
    for (int p = 0; p < NP; p++) begin m_optr[p] = 0; m_osid[p] = 0; end
    m_v = '0; m_g = '0; m_err = 0;
  endtask

  task automatic model_eval();
    for (int s = 0; s < NS; s++) taken[s] = 0;
    m_g = '0;
    for (int p = 0; p < NP; p++) begin
      int s;
      s = int'(i_rd_sid[p*SW +: SW]);
      nsid[p] = s;
      if (i_rd_v[p] && (!m_v[p] || o_addr_r[p]) && !(i_rst_v && int'(i_rst_sid) == s)
          && (m_av[s] - taken[s] > 0)) begin
        m_g[p]  = 1'b1;
        nptr[p] = (m_ptr[s] + taken[s]) % PMOD;
        taken[s]++;
      end
    end
  endtask

  task automatic model_commit();
    for (int p = 0; p < NP; p++) begin
      if (m_g[p]) begin
        m_v[p] = 1'b1; m_optr[p] = nptr[p]; m_osid[p] = nsid[p];
      end else if (o_addr_r[p]) begin
        m_v[p] = 1'b0;
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (i_rst_v && int'(i_rst_sid) == s) begin
        m_ptr[s] = 0; m_av[s] = 0;
      end else begin
        int a;
        m_ptr[s] = (m_ptr[s] + taken[s]) % PMOD;
        a = m_av[s] - taken[s] + ((i_fill_v && int'(i_fill_sid) == s) ? CL : 0);
        if (a > AMAX) begin a = AMAX; m_err = 1; end
        m_av[s] = a;
      end
    end
  endtask

  function automatic logic [NP*PW-1:0] exp_ptr_vec();
    logic [NP*PW-1:0] v;
    for (int p = 0; p < NP; p++) v[p*PW +: PW] = PW'(m_optr[p]);
    return v;
  endfunction

  function automatic logic [NP*SW-1:0] exp_sid_vec();
    logic [NP*SW-1:0] v;
    for (int p = 0; p < NP; p++) v[p*SW +: SW] = SW'(m_osid[p]);
    return v;
  endfunction

  function automatic logic exp_err();
`ifdef L1_RD_MPORT_ERR_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs at negedge, sample ready mid-low-phase, step past posedge.
  task automatic run_cycle(input logic [NP-1:0] rv, input logic [NP*SW-1:0] rs,
                           input logic fv, input logic [SW-1:0] fs,
                           input logic xv, input logic [SW-1:0] xs, input logic [NP-1:0] ar);
    @(negedge clk);
    i_rd_v = rv; i_rd_sid = rs; i_fill_v = fv; i_fill_sid = fs;
    i_rst_v = xv; i_rst_sid = xs; o_addr_r = ar;
    #2;
    got_rd_r = i_rd_r;
    model_eval();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_rd_v = '0; i_fill_v = 1'b0; i_rst_v = 1'b0; o_addr_r = '1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    string            name;
    logic [NP-1:0]    rd_v;
    logic [NP*SW-1:0] rd_sid;
    logic             fill_v;
    logic [SW-1:0]    fill_sid;
    logic             rst_v;
    logic [SW-1:0]    rst_sid;
    logic [NP-1:0]    addr_r;
    logic [NP-1:0]    exp_rd_r;
    logic [NP-1:0]    exp_v;
    logic [NP*PW-1:0] exp_ptr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input string nm, input logic [3:0] rv,
                               input int s0, input int s1, input int s2, input int s3,
                               input logic fv, input int fs, input logic xv, input int xs,
                               input logic [NP-1:0] ar, input logic [3:0] er, input logic [3:0] ev,
                               input int p0, input int p1, input int p2, input int p3);
    vec_t r;
    r.name = nm;
    r.rd_v = NP'(rv);
    r.rd_sid = '0;
    r.rd_sid[0*SW +: SW] = SW'(s0); r.rd_sid[1*SW +: SW] = SW'(s1);
    r.rd_sid[2*SW +: SW] = SW'(s2); r.rd_sid[3*SW +: SW] = SW'(s3);
    r.fill_v = fv; r.fill_sid = SW'(fs); r.rst_v = xv; r.rst_sid = SW'(xs);
    r.addr_r = ar; r.exp_rd_r = NP'(er); r.exp_v = NP'(ev);
    r.exp_ptr = '0;
    r.exp_ptr[0*PW +: PW] = PW'(p0); r.exp_ptr[1*PW +: PW] = PW'(p1);
    r.exp_ptr[2*PW +: PW] = PW'(p2); r.exp_ptr[3*PW +: PW] = PW'(p3);
    return r;
  endfunction

  initial begin
    // Single-port drain of one cacheline on sid 3; the ninth read finds no credit.
    tbl.push_back(row("fill3",      4'b0000, 0,0,0,0, 1,3, 0,0, 8'hFF, 4'b0000, 4'b0000, 0,0,0,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(row("rd3",      4'b0001, 3,0,0,0, 0,0, 0,0, 8'hFF, 4'b0001, 4'b0001, i,0,0,0));
    tbl.push_back(row("rd3_dry",    4'b0001, 3,0,0,0, 0,0, 0,0, 8'hFF, 4'b0000, 4'b0000, 7,0,0,0));
    // Same-cycle same-stream collisions on sid 5 get consecutive pointers.
    tbl.push_back(row("fill5",      4'b0000, 0,0,0,0, 1,5, 0,0, 8'hFF, 4'b0000, 4'b0000, 7,0,0,0));
    tbl.push_back(row("rd5x2",      4'b0011, 5,5,0,0, 1,5, 0,0, 8'hFF, 4'b0011, 4'b0011, 0,1,0,0));
    tbl.push_back(row("rd5x3",      4'b0111, 5,5,5,0, 0,0, 0,0, 8'hFF, 4'b0111, 4'b0111, 2,3,4,0));
    tbl.push_back(row("rd5_after",  4'b0001, 5,0,0,0, 0,0, 0,0, 8'hFF, 4'b0001, 4'b0001, 5,3,4,0));
    // Credit-limited grant on sid 1; a same-cycle fill is not usable until next cycle.
    tbl.push_back(row("fill1",      4'b0000, 0,0,0,0, 1,1, 0,0, 8'hFF, 4'b0000, 4'b0000, 5,3,4,0));
    tbl.push_back(row("rd1x4",      4'b1111, 1,1,1,1, 0,0, 0,0, 8'hFF, 4'b1111, 4'b1111, 0,1,2,3));
    tbl.push_back(row("rd1x2",      4'b0011, 1,1,0,0, 0,0, 0,0, 8'hFF, 4'b0011, 4'b0011, 4,5,2,3));
    tbl.push_back(row("rd1_short",  4'b1111, 1,1,1,1, 1,1, 0,0, 8'hFF, 4'b0011, 4'b0011, 6,7,2,3));
    tbl.push_back(row("rd1_refill", 4'b1100, 1,1,1,1, 0,0, 0,0, 8'hFF, 4'b1100, 4'b1100, 6,7,8,9));
    // Pointer wrap on sid 7.
    tbl.push_back(row("fill7",      4'b0000, 0,0,0,0, 1,7, 0,0, 8'hFF, 4'b0000, 4'b0000, 6,7,8,9));
    tbl.push_back(row("rd7_a",      4'b1111, 7,7,7,7, 1,7, 0,0, 8'hFF, 4'b1111, 4'b1111, 0,1,2,3));
    tbl.push_back(row("rd7_b",      4'b1111, 7,7,7,7, 0,0, 0,0, 8'hFF, 4'b1111, 4'b1111, 4,5,6,7));
    tbl.push_back(row("rd7_c",      4'b1111, 7,7,7,7, 1,7, 0,0, 8'hFF, 4'b1111, 4'b1111, 8,9,10,11));
    tbl.push_back(row("rd7_d",      4'b0011, 7,7,0,0, 0,0, 0,0, 8'hFF, 4'b0011, 4'b0011, 12,13,10,11));
    tbl.push_back(row("rd7_wrap",   4'b1111, 7,7,7,7, 0,0, 0,0, 8'hFF, 4'b1111, 4'b1111, 14,15,0,1));
    tbl.push_back(row("rd7_next",   4'b0001, 7,0,0,0, 0,0, 0,0, 8'hFF, 4'b0001, 4'b0001, 2,15,0,1));
    // Backpressure on port 0 for three cycles, then release.
    for (int i = 0; i < 3; i++)
      tbl.push_back(row("bp_hold",  4'b0001, 7,0,0,0, 0,0, 0,0, 8'hFE, 4'b0000, 4'b0001, 2,15,0,1));
    tbl.push_back(row("bp_release", 4'b0001, 7,0,0,0, 0,0, 0,0, 8'hFF, 4'b0001, 4'b0001, 3,15,0,1));
    tbl.push_back(row("idle",       4'b0000, 0,0,0,0, 0,0, 0,0, 8'hFF, 4'b0000, 4'b0000, 3,15,0,1));
    // Stream reset on sid 2 beats a same-cycle fill and refuses a same-cycle read.
    tbl.push_back(row("fill2",      4'b0000, 0,0,0,0, 1,2, 0,0, 8'hFF, 4'b0000, 4'b0000, 3,15,0,1));
    tbl.push_back(row("rd2x2",      4'b0110, 0,2,2,0, 0,0, 0,0, 8'hFF, 4'b0110, 4'b0110, 3,0,1,1));
    tbl.push_back(row("rst2",       4'b0001, 2,0,0,0, 1,2, 1,2, 8'hFF, 4'b0000, 4'b0000, 3,0,1,1));
    tbl.push_back(row("rd2_empty",  4'b0001, 2,0,0,0, 0,0, 0,0, 8'hFF, 4'b0000, 4'b0000, 3,0,1,1));
    tbl.push_back(row("fill2b",     4'b0000, 0,0,0,0, 1,2, 0,0, 8'hFF, 4'b0000, 4'b0000, 3,0,1,1));
    tbl.push_back(row("rd2_zero",   4'b0001, 2,0,0,0, 0,0, 0,0, 8'hFF, 4'b0001, 4'b0001, 0,0,1,1));

    // Reset state.
    do_reset();
    #1;
    chk("reset_addr_v", o_addr_v, '0);
    chk("reset_addr_ptr", o_addr_ptr, '0);
    chk("reset_addr_sid", o_addr_sid, '0);
    chk("reset_err", o_err, 1'b0);
    run_cycle('1, '0, 1'b0, '0, 1'b0, '0, '1);
    chk("reset_no_credit_rd_r", got_rd_r, '0);

    do_reset();
    foreach (tbl[i]) begin
      run_cycle(tbl[i].rd_v, tbl[i].rd_sid, tbl[i].fill_v, tbl[i].fill_sid,
                tbl[i].rst_v, tbl[i].rst_sid, tbl[i].addr_r);
      chk({tbl[i].name, "_rd_r"}, got_rd_r, tbl[i].exp_rd_r);
      chk({tbl[i].name, "_addr_v"}, o_addr_v, tbl[i].exp_v);
      chk({tbl[i].name, "_addr_ptr"}, o_addr_ptr, tbl[i].exp_ptr);
    end

`ifdef L1_RD_MPORT_ERR_EN
    // Four fills of 8 into a 5-bit counter saturate at 31 and raise the sticky error.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle('0, '0, 1'b1, '0, 1'b0, '0, '1);
      chk("sat_err", o_err, (i == 3) ? 1'b1 : 1'b0);
    end
    do_reset();
    #1;
    chk("err_cleared", o_err, 1'b0);
`endif

    // Randomized traffic over a few streams against the reference model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [NP-1:0]    rv;
      logic [NP*SW-1:0] rs;
      logic [NP-1:0]    ar;
      rv = NP'($urandom);
      ar = NP'($urandom) | NP'($urandom);
      rs = '0;
      for (int p = 0; p < NP; p++) rs[p*SW +: SW] = SW'($urandom_range(0, 3));
      run_cycle(rv, rs, ($urandom_range(0, 9) < 4), SW'($urandom_range(0, 3)),
                ($urandom_range(0, 29) == 0), SW'($urandom_range(0, 3)), ar);
      chk("rand_rd_r", got_rd_r, m_g);
      chk("rand_addr_v", o_addr_v, m_v);
      chk("rand_addr_ptr", o_addr_ptr, exp_ptr_vec());
      chk("rand_addr_sid", o_addr_sid, exp_sid_vec());
      chk("rand_err", o_err, exp_err());
    end

    // Asynchronous reset mid-cycle drops in-flight addresses immediately.
    run_cycle('0, '0, 1'b1, '0, 1'b1, 6'd1, '1);
    run_cycle(NP'(1), '0, 1'b0, '0, 1'b0, '0, '0);
    chk("pre_async_addr_v", o_addr_v, m_v);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_addr_v", o_addr_v, '0);
    chk("async_reset_addr_ptr", o_addr_ptr, '0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
